// File: rtl/goldschmidt_divider.sv
// Self-sequenced Goldschmidt divider for UQ1.F operands in [1,2).
// One shared multiplier is time-multiplexed across the scale and refinement states.
module goldschmidt_divider #(
  parameter int WIDTH = 16,
  parameter int ITER  = 4,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] ia_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] d_final
);

  localparam int F  = WIDTH - 1;
  localparam int PW = 2 * WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCALE_D = 3'd1,
    SCALE_N = 3'd2,
    ITER_D  = 3'd3,
    ITER_N  = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] n_cap;
  logic [WIDTH-1:0] d_cap;
  logic [WIDTH-1:0] ia_cap;
  logic [WIDTH-1:0] reg_n;
  logic [WIDTH-1:0] reg_d;
  logic [WIDTH:0]   k_reg;
  logic [3:0]       iter_cnt;
  logic             err_pend;

  logic [WIDTH:0]   k_comb;
  logic [WIDTH:0]   mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] prod_red;
  logic [4:0]       cnt_next;
  logic             last_iter;

  // Drop F fractional bits (optionally rounding half-up), saturating at 2.0.
  function automatic logic [WIDTH-1:0] reduce_prod(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    if (ROUND != 0) r = p + (PW'(1) << (F - 1));
    r = r >> F;
    if (r >= (PW'(1) << WIDTH)) return '1;
    return r[WIDTH-1:0];
  endfunction

  assign k_comb    = {1'b1, {WIDTH{1'b0}}} - {1'b0, reg_d};
  assign prod      = PW'(mul_a) * PW'(mul_b);
  assign prod_red  = reduce_prod(prod);
  assign cnt_next  = {1'b0, iter_cnt} + 5'd1;
  assign last_iter = (cnt_next >= 5'(ITER));

  always_comb begin
    mul_a = {1'b0, ia_cap};
    mul_b = d_cap;
    case (state)
      SCALE_N: mul_b = n_cap;
      ITER_D: begin
        mul_a = k_comb;
        mul_b = reg_d;
      end
      ITER_N: begin
        mul_a = k_reg;
        mul_b = reg_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_pend <= 1'b0;
      quotient <= '0;
      d_final  <= '0;
      n_cap    <= '0;
      d_cap    <= '0;
      ia_cap   <= '0;
      reg_n    <= '0;
      reg_d    <= '0;
      k_reg    <= '0;
      iter_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_cap  <= n_in;
            d_cap  <= d_in;
            ia_cap <= ia_in;
            // Operands below 1.0 bypass the datapath; err is published at FIN.
            if (!n_in[WIDTH-1] || !d_in[WIDTH-1]) begin
              err_pend <= 1'b1;
              state    <= FIN;
            end else begin
              err_pend <= 1'b0;
              busy     <= 1'b1;
              state    <= SCALE_D;
            end
          end
        end
        SCALE_D: begin
          reg_d <= prod_red;
          state <= SCALE_N;
        end
        SCALE_N: begin
          reg_n    <= prod_red;
          iter_cnt <= '0;
          state    <= (ITER > 0) ? ITER_D : FIN;
        end
        ITER_D: begin
          k_reg <= k_comb;
          reg_d <= prod_red;
          state <= ITER_N;
        end
        ITER_N: begin
          reg_n    <= prod_red;
          iter_cnt <= cnt_next[3:0];
          state    <= last_iter ? FIN : ITER_D;
        end
        FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          err      <= err_pend;
          quotient <= err_pend ? '0 : reg_n;
          d_final  <= reg_d;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
